// File: rtl/rans_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rans_pkg
//  Description : Shared constants, types and helpers for the multi-lane rANS
//                encoder array.
//  Contents    : DEF_* default parameter values, slot_t (holding-slot
//                record), lane_w() lane-index width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package rans_pkg;

    localparam int DEF_NUM_LANES      = 4;
    localparam int DEF_RESOLUTION     = 10;
    localparam int DEF_SYMBOL_WIDTH   = 8;
    localparam int DEF_FREQ_WR_CYCLES = 3;

    // One per-lane holding slot at the default byte width.
    typedef struct packed {
        logic                        valid;
        logic [DEF_SYMBOL_WIDTH-1:0] data;
    } slot_t;

    // Lane index width. It is never narrower than one bit, so a two-lane
    // array still has a real pointer that wraps 1 -> 0.
    function automatic int lane_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : rans_pkg
`default_nettype wire

// File: rtl/rans_lane_core.sv
`default_nettype none
// ============================================================================
//  Module      : rans_lane_core
//  Description : Single encoder lane. Each en_i pulse produces exactly one
//                registered byte one cycle later (enc_o = symb_i + 1).
//  Ports       : clk_i, rst_i (synchronous, active high), en_i step pulse,
//                freq_wr_i/freq_i/cum_freq_i frequency-table write,
//                symb_i symbol, valid_o/enc_o registered byte output.
//  Revision    : 1.0 - initial release
// ============================================================================
module rans_lane_core
    import rans_pkg::*;
#(
    parameter int RESOLUTION   = DEF_RESOLUTION,
    parameter int SYMBOL_WIDTH = DEF_SYMBOL_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    freq_wr_i,
    input  logic [RESOLUTION-1:0]   freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    input  logic [SYMBOL_WIDTH-1:0] symb_i,
    output logic                    valid_o,
    output logic [SYMBOL_WIDTH-1:0] enc_o
);

    // The frequency table does not shape this lane's output.
    logic unused_freq;
    assign unused_freq = ^{freq_wr_i, freq_i, cum_freq_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            enc_o   <= '0;
        end else begin
            valid_o <= en_i;
            if (en_i) begin
                enc_o <= symb_i + SYMBOL_WIDTH'(1);
            end
        end
    end

endmodule : rans_lane_core
`default_nettype wire

// File: rtl/rans_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rans_rr_arbiter
//  Description : Combinational round-robin picker. Scans the request vector
//                starting at i_start, wrapping, and grants the first set bit.
//  Ports       : i_req   - per-lane request vector
//                i_start - lane index where the scan begins
//                o_grant - one-hot grant (all zero when nothing requests)
//                o_idx   - index of the granted lane (0 when none)
//                o_any   - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rans_rr_arbiter
    import rans_pkg::*;
#(
    parameter  int NUM_LANES = DEF_NUM_LANES,
    localparam int LANE_W    = lane_w(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] i_req,
    input  logic [LANE_W-1:0]    i_start,
    output logic [NUM_LANES-1:0] o_grant,
    output logic [LANE_W-1:0]    o_idx,
    output logic                 o_any
);

    logic [LANE_W-1:0] w_cand;

    // NUM_LANES is a power of two, so truncating the sum to LANE_W bits is
    // exactly the modulo wrap of the scan.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_cand = i_start + LANE_W'(i);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule : rans_rr_arbiter
`default_nettype wire

// File: rtl/rans_lane_array.sv
`default_nettype none
// ============================================================================
//  Module      : rans_lane_array
//  Description : Multi-lane rANS encoder top. Symbols are dealt round-robin
//                to NUM_LANES lane cores; each lane's byte lands in a holding
//                slot, and a round-robin arbiter merges the slots onto one
//                backpressured stream tagged with the source lane.
//  Ports       : clk_i, rst_ni (async, active low)
//                freq_wr_i/freq_i/cum_freq_i/freq_ready_o - table write
//                symb_valid_i/symb_i/symb_ready_o         - symbol input
//                enc_valid_o/enc_o/enc_lane_o/enc_ready_i - encoded output
//  Revision    : 1.0 - initial release
// ============================================================================
module rans_lane_array
    import rans_pkg::*;
#(
    parameter  int NUM_LANES      = DEF_NUM_LANES,
    parameter  int RESOLUTION     = DEF_RESOLUTION,
    parameter  int SYMBOL_WIDTH   = DEF_SYMBOL_WIDTH,
    parameter  int FREQ_WR_CYCLES = DEF_FREQ_WR_CYCLES,
    localparam int LANE_W         = lane_w(NUM_LANES)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    freq_wr_i,
    input  logic [RESOLUTION-1:0]   freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    output logic                    freq_ready_o,
    input  logic                    symb_valid_i,
    input  logic [SYMBOL_WIDTH-1:0] symb_i,
    output logic                    symb_ready_o,
    output logic                    enc_valid_o,
    output logic [SYMBOL_WIDTH-1:0] enc_o,
    output logic [LANE_W-1:0]       enc_lane_o,
    input  logic                    enc_ready_i
);

    localparam int c_FCNT_W = (FREQ_WR_CYCLES < 1) ? 1 : $clog2(FREQ_WR_CYCLES + 1);

    logic [c_FCNT_W-1:0]     r_freq_cnt;
    logic [LANE_W-1:0]       disp_ptr_r;
    logic [LANE_W-1:0]       arb_ptr_r;
    logic [NUM_LANES-1:0]    pend_r;
    logic [NUM_LANES-1:0]    slot_full_r;
    logic [SYMBOL_WIDTH-1:0] slot_data_r [NUM_LANES];

    logic                    w_freq_accept;
    logic                    w_symb_accept;
    logic                    w_handshake;
    logic                    w_any_full;
    logic                    w_lane_rst;
    logic [LANE_W-1:0]       w_sel_idx;
    logic [NUM_LANES-1:0]    w_lane_freq_wr;
    logic [NUM_LANES-1:0]    w_eligible;
    logic [NUM_LANES-1:0]    w_lane_en;
    logic [NUM_LANES-1:0]    w_lane_valid;
    logic [NUM_LANES-1:0]    w_capture;
    logic [NUM_LANES-1:0]    w_grant;
    logic [NUM_LANES-1:0]    w_drain;
    logic [SYMBOL_WIDTH-1:0] w_lane_enc [NUM_LANES];

    // ---------------- frequency write: accept, broadcast, busy window
    assign freq_ready_o   = (r_freq_cnt == '0);
    assign w_freq_accept  = freq_wr_i && freq_ready_o;
    assign w_lane_freq_wr = {NUM_LANES{w_freq_accept}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_freq_cnt <= '0;
        end else if (w_freq_accept) begin
            r_freq_cnt <= c_FCNT_W'(FREQ_WR_CYCLES);
        end else if (r_freq_cnt != '0) begin
            r_freq_cnt <= r_freq_cnt - c_FCNT_W'(1);
        end
    end

    // ---------------- dispatch: strict round-robin, stall on busy lane
    // A lane is busy while its previous byte is still in flight (pend) or
    // still waiting in its slot, so a lane never holds more than one byte.
    assign w_eligible    = ~slot_full_r & ~pend_r;
    assign symb_ready_o  = freq_ready_o && !freq_wr_i && w_eligible[disp_ptr_r];
    assign w_symb_accept = symb_valid_i && symb_ready_o;
    assign w_lane_en     = w_symb_accept ? (NUM_LANES'(1) << disp_ptr_r) : '0;

    // ---------------- output merge
    assign w_capture   = pend_r & w_lane_valid;
    assign enc_valid_o = w_any_full;
    assign enc_o       = w_any_full ? slot_data_r[w_sel_idx] : '0;
    assign enc_lane_o  = w_sel_idx;
    assign w_handshake = enc_valid_o && enc_ready_i;
    assign w_drain     = w_handshake ? w_grant : '0;

    rans_rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_arb (
        .i_req   (slot_full_r),
        .i_start (arb_ptr_r),
        .o_grant (w_grant),
        .o_idx   (w_sel_idx),
        .o_any   (w_any_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            disp_ptr_r  <= '0;
            arb_ptr_r   <= '0;
            pend_r      <= '0;
            slot_full_r <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                slot_data_r[k] <= '0;
            end
        end else begin
            // The lane answers exactly one cycle after en_i, so pend is a
            // one-cycle echo of the enable.
            pend_r      <= w_lane_en;
            // Capture and drain never target the same lane: a full slot is
            // never re-dispatched, so it cannot also be capturing.
            slot_full_r <= (slot_full_r & ~w_drain) | w_capture;
            if (w_symb_accept) begin
                disp_ptr_r <= disp_ptr_r + LANE_W'(1);
            end
            if (w_handshake) begin
                arb_ptr_r <= w_sel_idx + LANE_W'(1);
            end
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_capture[k]) begin
                    slot_data_r[k] <= w_lane_enc[k];
                end
            end
        end
    end

    // ---------------- lane cores
    assign w_lane_rst = !rst_ni;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        rans_lane_core #(
            .RESOLUTION   (RESOLUTION),
            .SYMBOL_WIDTH (SYMBOL_WIDTH)
        ) u_core (
            .clk_i      (clk_i),
            .rst_i      (w_lane_rst),
            .en_i       (w_lane_en[k]),
            .freq_wr_i  (w_lane_freq_wr[k]),
            .freq_i     (freq_i),
            .cum_freq_i (cum_freq_i),
            .symb_i     (symb_i),
            .valid_o    (w_lane_valid[k]),
            .enc_o      (w_lane_enc[k])
        );
    end

endmodule : rans_lane_array
`default_nettype wire

// File: tb/tb_rans_lane_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rans_lane_array
//  Description : Self-checking bench for rans_lane_array (4 lanes). A monitor
//                pushes the expected byte/lane for every accepted symbol and
//                pops and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rans_lane_array;

    localparam int NL  = 4;
    localparam int RES = 10;
    localparam int SW  = 8;
    localparam int FWC = 3;
    localparam int LW  = 2;

    logic           clk        = 1'b0;
    logic           rst_n      = 1'b0;
    logic           freq_wr    = 1'b0;
    logic [RES-1:0] freq       = '0;
    logic [RES-1:0] cum_freq   = '0;
    logic           freq_ready;
    logic           symb_valid = 1'b0;
    logic [SW-1:0]  symb       = '0;
    logic           symb_ready;
    logic           enc_valid;
    logic [SW-1:0]  enc;
    logic [LW-1:0]  enc_lane;
    logic           enc_ready  = 1'b0;

    always #5 clk = ~clk;

    rans_lane_array #(
        .NUM_LANES      (NL),
        .RESOLUTION     (RES),
        .SYMBOL_WIDTH   (SW),
        .FREQ_WR_CYCLES (FWC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .freq_wr_i    (freq_wr),
        .freq_i       (freq),
        .cum_freq_i   (cum_freq),
        .freq_ready_o (freq_ready),
        .symb_valid_i (symb_valid),
        .symb_i       (symb),
        .symb_ready_o (symb_ready),
        .enc_valid_o  (enc_valid),
        .enc_o        (enc),
        .enc_lane_o   (enc_lane),
        .enc_ready_i  (enc_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
        end
    endtask

    // ---------------- scoreboard monitor (samples mid-cycle, after drive)
    logic [LW+SW-1:0] sb [$];
    int               model_disp = 0;
    bit               mon_en     = 1'b0;
    bit               prev_stall = 1'b0;
    logic [SW-1:0]    prev_enc   = '0;
    logic [LW-1:0]    prev_lane  = '0;
    int               out_cnt    = 0;

    always @(negedge clk) begin
        logic [LW+SW-1:0] e;
        #2;
        if (mon_en) begin
            if (prev_stall) begin
                chk("hold_valid", enc_valid, 1);
                chk("hold_byte", enc, prev_enc);
                chk("hold_lane", enc_lane, prev_lane);
            end
            if (symb_valid && symb_ready) begin
                sb.push_back({LW'(model_disp), symb + 8'd1});
                model_disp = (model_disp + 1) % NL;
            end
            if (enc_valid && enc_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_empty_on_output", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("enc_byte", enc, e[SW-1:0]);
                    chk("enc_lane", enc_lane, e[LW+SW-1:SW]);
                end
                out_cnt++;
            end
            prev_stall = enc_valid && !enc_ready;
            prev_enc   = enc;
            prev_lane  = enc_lane;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers
    task automatic send(input logic [SW-1:0] s, output int waits);
        waits = 0;
        @(negedge clk);
        symb_valid = 1'b1;
        symb       = s;
        #1;
        while (!symb_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 200) begin
            chk("send_timeout", waits, 0);
            symb_valid = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        symb_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached limit 100000", $time);
        $fatal(1);
    end

    initial begin
        int w;
        int base;
        int stall_ready;

        // ---------------- reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_enc_valid_low", enc_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_freq_ready", freq_ready, 1);
        chk("rst_symb_ready", symb_ready, 1);
        chk("rst_enc_valid", enc_valid, 0);
        chk("rst_enc_lane", enc_lane, 0);
        chk("rst_enc_byte", enc, 0);
        mon_en = 1'b1;

        // ---------------- frequency write at t, second write at t+2 ignored
        @(negedge clk);
        freq_wr = 1'b1; freq = 10'd100; cum_freq = 10'd20;
        #1;
        chk("fw_strobe_t", dut.w_lane_freq_wr, 4'hF);
        chk("fw_symb_ready_t", symb_ready, 0);
        @(negedge clk);
        freq_wr = 1'b0;
        #1;
        chk("fw_ready_t1", freq_ready, 0);
        chk("fw_symb_ready_t1", symb_ready, 0);
        @(negedge clk);
        freq_wr = 1'b1;
        #1;
        chk("fw_ignored_strobe", dut.w_lane_freq_wr, 0);
        chk("fw_ready_t2", freq_ready, 0);
        @(negedge clk);
        freq_wr = 1'b0;
        #1;
        chk("fw_ready_t3", freq_ready, 0);
        chk("fw_symb_ready_t3", symb_ready, 0);
        @(negedge clk);
        #1;
        chk("fw_ready_t4", freq_ready, 1);
        chk("fw_symb_ready_t4", symb_ready, 1);

        // ---------------- streaming, no backpressure
        enc_ready = 1'b1;
        base = out_cnt;
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i), w);
            chk("stream_no_stall", w, 0);
        end
        idle();
        drain("stream_drain");
        chk("stream_count", out_cnt - base, 8);

        // ---------------- simultaneous freq write and symbol
        base = out_cnt;
        @(negedge clk);
        freq_wr = 1'b1; symb_valid = 1'b1; symb = 8'h30;
        #1;
        chk("sim_symb_ready_t", symb_ready, 0);
        chk("sim_strobe_t", dut.w_lane_freq_wr, 4'hF);
        @(negedge clk);
        freq_wr = 1'b0;
        w = 1;
        #1;
        while (!symb_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("sim_accept_cycle", w, 4);
        idle();
        drain("sim_drain");
        chk("sim_count", out_cnt - base, 1);

        // ---------------- backpressure: 4 accepted, then stall
        enc_ready = 1'b0;
        base = out_cnt;
        for (int i = 0; i < 4; i++) begin
            send(8'h20 + 8'(i), w);
            chk("bp_accept_no_wait", w, 0);
        end
        @(negedge clk);
        symb_valid = 1'b1; symb = 8'h24;
        stall_ready = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (symb_ready) stall_ready++;
            @(negedge clk);
        end
        chk("bp_stall_ready_cycles", stall_ready, 0);
        chk("bp_valid_while_full", enc_valid, 1);
        chk("bp_no_output_yet", out_cnt - base, 0);
        enc_ready = 1'b1;
        w = 0;
        #1;
        while (!symb_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("bp_resume_timeout", w < 20, 1);
        send(8'h25, w);
        idle();
        drain("bp_drain");
        chk("bp_count", out_cnt - base, 6);

        // ---------------- reset mid-stream with 3 slots full
        enc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(8'h40 + 8'(i), w);
        end
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk("mid_slots_valid", enc_valid, 1);
        @(negedge clk);
        freq_wr = 1'b1;
        @(negedge clk);
        freq_wr = 1'b0;
        #1;
        chk("mid_freq_busy", freq_ready, 0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_enc_valid", enc_valid, 0);
        chk("mid_rst_freq_ready", freq_ready, 1);
        sb.delete();
        model_disp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_post_enc_valid", enc_valid, 0);
        chk("mid_post_symb_ready", symb_ready, 1);
        mon_en    = 1'b1;
        enc_ready = 1'b1;
        base = out_cnt;
        send(8'h50, w);
        chk("mid_first_no_wait", w, 0);
        idle();
        drain("mid_drain");
        chk("mid_count", out_cnt - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rans_lane_array
`default_nettype wire
